mmio_port_controller: RTL
=========================

Name: mmio_port_controller

Overview:
Memory-mapped I/O responder on the processor's data bus. It gives load/store instructions access to the external 8-bit input port and the 32-bit output port. It synchronises PortIn and flags changes on it. It drives PortOut through a four-phase valid/ack handshake with the external consumer. Reads are combinational so a single-cycle load completes in its own cycle; all register side effects occur on the clock edge.

Parameters:
BASE_ADDRESS, 32'h1001_0000, base of the 16-byte register window (bits [3:0] must be 0)
IN_WIDTH, 8, width of PortIn; zero-extended to 32 bits on read

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
Address  input  32  byte address from ALU result
WriteData  input  32  store data (rt)
MemWrite  input  1  store strobe, sampled at rising clk
MemRead  input  1  load strobe; qualifies read side effects
ReadData  output  32  combinational load data
PortIn  input  IN_WIDTH  asynchronous external input
PortOut  output  32  output data register
PortOutValid  output  1  handshake request to consumer
PortOutAck  input  1  asynchronous handshake acknowledge from consumer

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high.
- Decode: hit = (Address[31:4] == BASE_ADDRESS[31:4]). Register selected by Address[3:2]; Address[1:0] ignored.
- Register map:
  - 0x0 OUT_DATA: R = PortOut. W = start transfer.
  - 0x4 STATUS: R = {29'b0, overrun, in_changed, busy}. W = W1C for bit1 and bit2.
  - 0x8 IN_DATA: R = synchronised PortIn, zero-extended.
  - 0xC reserved: reads 0, writes ignored.
- ReadData = selected register when hit, else 32'h0. It is independent of MemRead. Outside the window, writes have no effect.
- Reset values: PortOut 0, PortOutValid 0, state IDLE, in_changed 0, overrun 0, all synchroniser flops 0, in_prev 0.
- Input path:
  - Two-flop synchroniser sync1 -> sync2; IN_DATA = sync2. An edge-k change of PortIn is readable after edge k+1.
  - in_prev <= sync2 every cycle.
  - in_changed sets when sync2 != in_prev, i.e. after edge k+2.
  - in_changed clears on a load of IN_DATA (hit & MemRead & offset 0x8) or on a write of 1 to STATUS bit1.
  - Set and clear in the same cycle: set wins.
- Output handshake: PortOutAck passes through a two-flop synchroniser to give ack_s. FSM states:
  - IDLE: PortOutValid=0, busy=0. A store to OUT_DATA loads PortOut <= WriteData and moves to REQ.
  - REQ: PortOutValid=1, busy=1. When ack_s=1, move to RELEASE.
  - RELEASE: PortOutValid=0, busy=1. When ack_s=0, move to IDLE.
- PortOut changes only on the IDLE->REQ edge and is stable through REQ and RELEASE.
- A store to OUT_DATA while busy is dropped: PortOut is unchanged, overrun <= 1, and the FSM is unaffected.
- overrun clears only on a write of 1 to STATUS bit2. A new overrun in the same cycle as the clear: set wins.
- busy reads as 1 in the cycle the FSM enters REQ. A back-to-back store in the next cycle therefore overruns.
- Reset asserted mid-handshake immediately forces PortOutValid=0 and IDLE and clears PortOut. The consumer must tolerate an abandoned request.
- MemWrite and MemRead both asserted: the write takes effect and read side effects also apply.

Test Plan:
- Reset: assert reset mid-REQ with PortOut=32'hDEAD_BEEF -> PortOut=0, PortOutValid=0 asynchronously. After release, STATUS reads 0.
- Input sync: PortIn 8'h00->8'hA5 before edge 0 -> IN_DATA reads 32'hA5 after edge 1. STATUS bit1=1 after edge 2. A load of 0x1001_0008 clears bit1 at the next edge; STATUS then reads 0.
- Handshake: store 32'h1234_5678 to 0x1001_0000 -> PortOut=32'h1234_5678 and PortOutValid=1 next cycle. Raise PortOutAck -> valid drops 3 cycles later (sync + FSM). Lower ack -> STATUS busy=0 3 cycles later.
- Overrun: in REQ, store 32'hFFFF_FFFF to OUT_DATA -> PortOut keeps 32'h1234_5678 and STATUS=32'h5. Store 32'h4 to STATUS -> STATUS=32'h1.
- Set-wins: PortIn changes so in_changed sets in the same cycle as an IN_DATA load -> in_changed remains 1.
- Decode: store 32'h77 to 0x1001_0010 and 0x1001_000C -> no state change; reads of both return 0. A read at 0x1001_0003 returns the OUT_DATA value.

Source files
------------

// File: rtl/mmio_port_controller.sv
// rtl/mmio_port_controller.sv - MMIO responder for an 8-bit input port and a 32-bit handshaked output port
module mmio_port_controller #(
  parameter logic [31:0] BASE_ADDRESS = 32'h1001_0000,
  parameter int          IN_WIDTH     = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         Address,
  input  logic [31:0]         WriteData,
  input  logic                MemWrite,
  input  logic                MemRead,
  output logic [31:0]         ReadData,
  input  logic [IN_WIDTH-1:0] PortIn,
  output logic [31:0]         PortOut,
  output logic                PortOutValid,
  input  logic                PortOutAck
);

  typedef enum logic [1:0] {IDLE, REQ, RELEASE} state_t;

  state_t              state, next_state;
  logic [IN_WIDTH-1:0] sync1, sync2, in_prev;
  logic                in_changed, overrun;
  logic                ack1, ack_s;
  logic                hit, busy;
  logic [1:0]          sel;
  logic                store_out, store_status, load_in;
  logic                load_port, set_changed, clr_changed, set_overrun, clr_overrun;

  assign hit          = (Address[31:4] == BASE_ADDRESS[31:4]);
  assign sel          = Address[3:2];
  assign busy         = (state != IDLE);
  assign store_out    = hit & MemWrite & (sel == 2'd0);
  assign store_status = hit & MemWrite & (sel == 2'd1);
  assign load_in      = hit & MemRead  & (sel == 2'd2);

  assign set_changed  = (sync2 != in_prev);
  assign clr_changed  = load_in | (store_status & WriteData[1]);
  // A store that finds the port busy is dropped and only recorded as an overrun.
  assign set_overrun  = store_out & busy;
  assign clr_overrun  = store_status & WriteData[2];

  always_comb begin
    ReadData = 32'h0;
    if (hit) begin
      case (sel)
        2'd0:    ReadData = PortOut;
        2'd1:    ReadData = {29'b0, overrun, in_changed, busy};
        2'd2:    ReadData = {{(32-IN_WIDTH){1'b0}}, sync2};
        default: ReadData = 32'h0;
      endcase
    end
  end

  always_comb begin
    next_state   = state;
    load_port    = 1'b0;
    PortOutValid = 1'b0;
    case (state)
      IDLE: begin
        if (store_out) begin
          next_state = REQ;
          load_port  = 1'b1;
        end
      end
      REQ: begin
        PortOutValid = 1'b1;
        if (ack_s) next_state = RELEASE;
      end
      RELEASE: begin
        if (!ack_s) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      PortOut    <= 32'h0;
      sync1      <= '0;
      sync2      <= '0;
      in_prev    <= '0;
      in_changed <= 1'b0;
      overrun    <= 1'b0;
      ack1       <= 1'b0;
      ack_s      <= 1'b0;
    end else begin
      state   <= next_state;
      sync1   <= PortIn;
      sync2   <= sync1;
      in_prev <= sync2;
      ack1    <= PortOutAck;
      ack_s   <= ack1;
      if (load_port) PortOut <= WriteData;
      // Sets take priority over clears for both sticky flags.
      if (set_changed)      in_changed <= 1'b1;
      else if (clr_changed) in_changed <= 1'b0;
      if (set_overrun)      overrun <= 1'b1;
      else if (clr_overrun) overrun <= 1'b0;
    end
  end

endmodule
